// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : instruction/data port arbiter onto a single word memory
//               with sub-word store masking, load extension, starve limit.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_unsigned,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic [3:0]  mem_wm,
    input  logic [31:0] mem_rd
);

    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic [3:0]  starve_q, starve_d;
    logic        i_rvalid_q, i_rvalid_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic        d_err_q, d_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        w_i_win;
    logic        w_d_gnt;
    logic        w_i_gnt;
    logic        w_legal;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Grants are forced low while in reset so nothing reaches memory.
    always_comb begin
        w_i_win = i_req && (starve_q == LIMIT);
        w_d_gnt = reset_n && d_req && !w_i_win;
        w_i_gnt = reset_n && i_req && !w_d_gnt;
    end

    always_comb begin
        w_legal = 1'b0;
        case (d_size)
            SIZE_BYTE: w_legal = 1'b1;
            SIZE_HALF: w_legal = !d_addr[0];
            SIZE_WORD: w_legal = (d_addr[1:0] == 2'b00);
            default:   w_legal = 1'b0;
        endcase
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wm = 4'b0000;
        mem_wd = d_wdata;
        mem_a  = i_addr;
        if (w_d_gnt) begin
            mem_a = d_addr;
            case (d_size)
                SIZE_BYTE: mem_wd = {4{d_wdata[7:0]}};
                SIZE_HALF: mem_wd = {2{d_wdata[15:0]}};
                default:   mem_wd = d_wdata;
            endcase
            if (d_we && w_legal) begin
                mem_we = 1'b1;
                case (d_size)
                    SIZE_BYTE: mem_wm = 4'b0001 << d_addr[1:0];
                    SIZE_HALF: mem_wm = 4'b0011 << d_addr[1:0];
                    default:   mem_wm = 4'b1111;
                endcase
            end
        end
    end

    always_comb begin
        case (d_addr[1:0])
            2'd0:    w_byte = mem_rd[7:0];
            2'd1:    w_byte = mem_rd[15:8];
            2'd2:    w_byte = mem_rd[23:16];
            default: w_byte = mem_rd[31:24];
        endcase
        w_half = d_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (d_size)
            SIZE_BYTE: w_load = {{24{w_byte[7] & !d_unsigned}}, w_byte};
            SIZE_HALF: w_load = {{16{w_half[15] & !d_unsigned}}, w_half};
            default:   w_load = mem_rd;
        endcase
    end

    // Starve counter tracks data grants won while a fetch is waiting.
    always_comb begin
        starve_d = starve_q;
        if (w_i_gnt || !i_req) begin
            starve_d = 4'd0;
        end else if (w_d_gnt && starve_q != LIMIT) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_comb begin
        i_rvalid_d = w_i_gnt;
        i_rdata_d  = w_i_gnt ? mem_rd : i_rdata_q;
        d_rvalid_d = w_d_gnt;
        d_err_d    = w_d_gnt && !w_legal;
        d_rdata_d  = d_rdata_q;
        if (w_d_gnt) begin
            d_rdata_d = (!d_we && w_legal) ? w_load : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q   <= 4'd0;
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= 32'd0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= 32'd0;
        end else begin
            starve_q   <= starve_d;
            i_rvalid_q <= i_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rvalid_q <= d_rvalid_d;
            d_err_q    <= d_err_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign i_gnt    = w_i_gnt;
    assign d_gnt    = w_d_gnt;
    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_err    = d_err_q;
    assign d_rdata  = d_rdata_q;

endmodule

`default_nettype wire
